// File: rtl/phased_tx_pkg.sv
// Shared constants and state encoding for the phased transducer burst engine.
package phased_tx_pkg;

   localparam logic [7:0] ADDR_DUTY      = 8'h01;
   localparam logic [7:0] ADDR_BURST     = 8'h02;
   localparam logic [7:0] ADDR_CHAN_BASE = 8'h10;

   localparam int unsigned CHAN_EN_BIT  = 7;
   localparam int unsigned CHAN_INV_BIT = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } tx_state_e;

endpackage

// File: rtl/phased_tx_channel.sv
// One transducer channel: active-window test and duty compare against the burst counter.
// PHASED_TX_INVERT_EN adds a per-channel polarity flip inside the active window.
module phased_tx_channel #(
   parameter int unsigned PHASE_BITS = 4,
   parameter int unsigned T_W        = 9
) (
   input  logic [T_W-1:0]        t,
   input  logic [T_W-1:0]        win_len,
   input  logic [PHASE_BITS:0]   duty,
   input  logic                  en,
   input  logic [PHASE_BITS-1:0] shift,
`ifdef PHASED_TX_INVERT_EN
   input  logic                  inv,
`endif
   output logic                  drive_c
);

   logic [T_W-1:0] rel;
   logic           active;
   logic           level;

   // rel is only meaningful once t has passed the shift, hence the explicit t >= shift term
   always_comb begin
      rel    = t - T_W'(shift);
      active = en && (t >= T_W'(shift)) && (rel < win_len);
      level  = {1'b0, rel[PHASE_BITS-1:0]} < duty;
`ifdef PHASED_TX_INVERT_EN
      drive_c = active & (level ^ inv);
`else
      drive_c = active & level;
`endif
   end

endmodule

// File: rtl/phased_tx_engine.sv
// Phased-array burst generator: config registers, burst shadowing, IDLE/RUN/TAIL sequencing.
// Optional feature: define PHASED_TX_INVERT_EN for per-channel output inversion (chan bit6).
module phased_tx_engine #(
   parameter int unsigned N_CH       = 37,
   parameter int unsigned PHASE_BITS = 4,
   parameter int unsigned BURST_BITS = 4
) (
   input  logic            clk,
   input  logic            res_n,
   input  logic            tick,
   input  logic            start,
   input  logic            cfg_we,
   input  logic [7:0]      cfg_addr,
   input  logic [7:0]      cfg_wdata,
   output logic [N_CH-1:0] tx_out,
   output logic            busy,
   output logic            done
);
   import phased_tx_pkg::*;

   localparam int unsigned T_W    = PHASE_BITS + BURST_BITS + 1;
   localparam int unsigned DUTY_W = PHASE_BITS + 1;
   localparam int unsigned PERIOD = 1 << PHASE_BITS;

   // Live configuration
   logic [DUTY_W-1:0]     duty;
   logic [BURST_BITS-1:0] burst_len;
   logic [N_CH-1:0]       chan_en;
   logic [PHASE_BITS-1:0] chan_shift [N_CH];

   // Snapshot used by the burst in flight
   logic [DUTY_W-1:0]     sh_duty;
   logic [BURST_BITS-1:0] sh_burst;
   logic [N_CH-1:0]       sh_en;
   logic [PHASE_BITS-1:0] sh_shift [N_CH];

`ifdef PHASED_TX_INVERT_EN
   logic [N_CH-1:0]       chan_inv;
   logic [N_CH-1:0]       sh_inv;
`endif

   tx_state_e       state;
   logic [T_W-1:0]  t;
   logic [T_W-1:0]  win_len;
   logic [T_W-1:0]  run_last;
   logic [T_W-1:0]  tail_last;
   logic [N_CH-1:0] drive_c;
   logic            wdata_unused;

   assign wdata_unused = ^cfg_wdata;

   assign win_len   = T_W'(sh_burst) << PHASE_BITS;
   assign run_last  = win_len - T_W'(1);
   assign tail_last = win_len + T_W'(PERIOD - 1);

   // Configuration register file
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         duty      <= '0;
         burst_len <= '0;
         chan_en   <= '0;
`ifdef PHASED_TX_INVERT_EN
         chan_inv  <= '0;
`endif
         for (int i = 0; i < int'(N_CH); i++) begin
            chan_shift[i] <= '0;
         end
      end else if (cfg_we) begin
         if (cfg_addr == ADDR_DUTY) begin
            duty <= DUTY_W'(cfg_wdata);
         end
         if (cfg_addr == ADDR_BURST) begin
            burst_len <= BURST_BITS'(cfg_wdata);
         end
         for (int i = 0; i < int'(N_CH); i++) begin
            if (cfg_addr == ADDR_CHAN_BASE + 8'(i)) begin
               chan_en[i]    <= cfg_wdata[CHAN_EN_BIT];
               chan_shift[i] <= PHASE_BITS'(cfg_wdata);
`ifdef PHASED_TX_INVERT_EN
               chan_inv[i]   <= cfg_wdata[CHAN_INV_BIT];
`endif
            end
         end
      end
   end

   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      phased_tx_channel #(
         .PHASE_BITS (PHASE_BITS),
         .T_W        (T_W)
      ) u_ch (
         .t       (t),
         .win_len (win_len),
         .duty    (sh_duty),
         .en      (sh_en[i]),
         .shift   (sh_shift[i]),
`ifdef PHASED_TX_INVERT_EN
         .inv     (sh_inv[i]),
`endif
         .drive_c (drive_c[i])
      );
   end

   // Burst sequencer; the shadow copy samples pre-write config when start and cfg_we coincide
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= ST_IDLE;
         t        <= '0;
         tx_out   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sh_duty  <= '0;
         sh_burst <= '0;
         sh_en    <= '0;
`ifdef PHASED_TX_INVERT_EN
         sh_inv   <= '0;
`endif
         for (int i = 0; i < int'(N_CH); i++) begin
            sh_shift[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && (burst_len != '0)) begin
                  sh_duty  <= duty;
                  sh_burst <= burst_len;
                  sh_en    <= chan_en;
`ifdef PHASED_TX_INVERT_EN
                  sh_inv   <= chan_inv;
`endif
                  for (int i = 0; i < int'(N_CH); i++) begin
                     sh_shift[i] <= chan_shift[i];
                  end
                  t     <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  tx_out <= drive_c;
                  t      <= t + T_W'(1);
                  if (t == run_last) begin
                     state <= ST_TAIL;
                  end
               end
            end
            ST_TAIL: begin
               if (tick) begin
                  if (t == tail_last) begin
                     tx_out <= '0;
                     t      <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     tx_out <= drive_c;
                     t      <= t + T_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/phased_tx_engine.md
PHASED_TX_ENGINE -- requirements
Module: phased_tx_engine

Interface
REQ-001 SHALL have parameter N_CH, default 37, number of transducer channels (1..64).
REQ-002 SHALL have parameter PHASE_BITS, default 4, phase resolution; one carrier period = 2^PHASE_BITS ticks.
REQ-003 SHALL have parameter BURST_BITS, default 4, width of burst-length register.
REQ-004 SHALL have port clk, input, 1, single system clock.
REQ-005 SHALL have port res_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tick, input, 1, clock enable; one tick = one phase step.
REQ-007 SHALL have port start, input, 1, single-cycle burst request.
REQ-008 SHALL have port cfg_we, input, 1, config write strobe.
REQ-009 SHALL have port cfg_addr, input, 8, config address.
REQ-010 SHALL have port cfg_wdata, input, 8, config write data.
REQ-011 SHALL have port tx_out, output, N_CH, registered channel drive.
REQ-012 SHALL have port busy, output, 1, high while burst in progress.
REQ-013 SHALL have port done, output, 1, one-clk pulse at burst completion.

Function
REQ-014 SHALL decode on cfg_we: 0x01 duty[PHASE_BITS:0]; 0x02 burst_len[BURST_BITS-1:0]; 0x10+i (i<N_CH) chan[i]: bit7 enable, [PHASE_BITS-1:0] shift; other addresses ignored.
REQ-015 SHALL copy duty, burst_len and all chan[i] into shadow registers on start acceptance; writes during a burst affect only the next burst.
REQ-016 On start+cfg_we in same cycle, shadow SHALL capture pre-write values.
REQ-017 FSM states IDLE, RUN, TAIL; IDLE->RUN on start with burst_len!=0; start ignored when burst_len==0 or state!=IDLE.
REQ-018 In RUN/TAIL, counter t SHALL start at 0 and increment once per tick, width PHASE_BITS+BURST_BITS+1.
REQ-019 RUN->TAIL when t reaches burst_len*2^PHASE_BITS-1 on a tick; TAIL->IDLE when t reaches (burst_len+1)*2^PHASE_BITS-1 on a tick.
REQ-020 Channel i SHALL be active for shift_i <= t < shift_i + burst_len*2^PHASE_BITS, enable set; else output 0.
REQ-021 When active, tx_out[i] SHALL be 1 iff ((t-shift_i) mod 2^PHASE_BITS) < duty; duty >= 2^PHASE_BITS gives constant 1, duty 0 constant 0.
REQ-022 tx_out SHALL update only on clk edges where tick=1, reflecting that tick's t (1-clk latency); held otherwise.
REQ-023 busy SHALL rise the clk after start acceptance and fall with the done pulse.
REQ-024 done SHALL pulse one clk after the final TAIL tick; tx_out all 0 at that edge.
REQ-025 Every enabled channel SHALL emit exactly burst_len full periods regardless of shift.

Reset
REQ-026 res_n low SHALL asynchronously force state IDLE, t=0, tx_out=0, busy=0, done=0, duty=0, burst_len=0, all chan and shadow registers 0.
REQ-027 Reset mid-burst SHALL abort immediately; no done pulse.

Configuration
REQ-028 With PHASED_TX_INVERT_EN defined, chan[i] bit6 SHALL invert tx_out[i] while channel is active only; idle level stays 0.
REQ-029 Without PHASED_TX_INVERT_EN, bit6 SHALL be ignored and no invert storage synthesised.

Structure
REQ-030 Package phased_tx_pkg SHALL hold address constants (ADDR_DUTY, ADDR_BURST, ADDR_CHAN_BASE) and FSM state enum.
REQ-031 Per-channel active window and duty compare SHALL be sub-module phased_tx_channel, instantiated N_CH times.

Verification
REQ-032 duty=8, burst_len=2, ch0 en shift0, start, tick every clk -> tx_out[0] 8 high/8 low twice, done after 48 ticks.
REQ-033 ch1 shift=15, burst_len=1 -> tx_out[1] rises at t=15, exactly 8 high ticks, low by t=31; done at t=31.
REQ-034 burst_len=0, start -> busy stays 0, no done; start while busy -> ignored, no restart.
REQ-035 write duty=4 mid-burst (duty was 8) -> current burst keeps 8-tick highs; next burst 4.
REQ-036 res_n low at t=10 -> tx_out=0, busy=0 immediately, no done; fresh start runs normally.
